// File: rtl/sramlike_arbiter_2x1_pkg.sv
// Shared types for the 2:1 SRAM-like arbiter.
// - arb_owner_e : which requester owns a grant or an outstanding transaction
// - arb_lock_e  : grant lock state (held while a request waits for addr_ok)
package sramlike_arbiter_2x1_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_lock_e;

endpackage

// File: rtl/sramlike_arbiter_2x1_owner_fifo.sv
// In-order FIFO of transaction owners (1-bit entries).
// Ports:
// - clk, resetn      : clock, synchronous active-low reset
// - push, push_owner : enqueue the owner of a newly accepted transaction
// - pop              : dequeue the head (caller guarantees count != 0)
// - count            : number of stored entries
// - head             : owner at the head of the queue
module sramlike_arbiter_2x1_owner_fifo
  import sramlike_arbiter_2x1_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  arb_owner_e       push_owner,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output arb_owner_e       head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  arb_owner_e mem_q [DEPTH];
  arb_owner_e mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_owner;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sramlike_arbiter_2x1.sv
// 2:1 arbiter sharing one SRAM-like downstream port between an inst (I) and a data (D) requester.
// Fixed priority D > I; the grant is locked while a request waits for addr_ok so the downstream
// fields stay stable. Outstanding owners are queued in order to route data_ok back.
// Ports:
// - clk, resetn                          : clock, synchronous active-low reset
// - i_req/i_wr/i_size/i_addr/i_wdata     : inst requester command
// - i_rdata/i_addr_ok/i_data_ok          : inst requester responses
// - d_req/d_wr/d_size/d_addr/d_wdata     : data requester command
// - d_rdata/d_addr_ok/d_data_ok          : data requester responses
// - m_req/m_wr/m_size/m_addr/m_wdata     : downstream command (muxed from granted requester)
// - m_rdata/m_addr_ok/m_data_ok          : downstream responses (in order)
module sramlike_arbiter_2x1
  import sramlike_arbiter_2x1_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] i_rdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  arb_lock_e  lock_q, lock_d;
  arb_owner_e lock_owner_q, lock_owner_d;
  arb_owner_e grant;
  arb_owner_e head;
  logic [CNT_W-1:0] count;
  logic gnt_req, not_full, accept, ret;

  sramlike_arbiter_2x1_owner_fifo #(
    .DEPTH (MAX_OUTST),
    .CNT_W (CNT_W)
  ) u_owner_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_owner (grant),
    .pop        (ret),
    .count      (count),
    .head       (head)
  );

  always_comb begin
    grant = OWN_I;
    if (lock_q == ARB_LOCKED) begin
      grant = lock_owner_q;
    end else if (d_req) begin
      grant = OWN_D;
    end
  end

  assign gnt_req  = (grant == OWN_D) ? d_req : i_req;
  // Registered count only: a same-cycle return does not free a slot for a new accept.
  assign not_full = (count != CNT_W'(MAX_OUTST));
  // resetn gating keeps every handshake quiet during the reset cycle.
  assign m_req    = resetn & gnt_req & not_full;
  assign accept   = m_req & m_addr_ok;
  assign ret      = resetn & m_data_ok & (count != '0);

  assign m_wr    = (grant == OWN_D) ? d_wr    : i_wr;
  assign m_size  = (grant == OWN_D) ? d_size  : i_size;
  assign m_addr  = (grant == OWN_D) ? d_addr  : i_addr;
  assign m_wdata = (grant == OWN_D) ? d_wdata : i_wdata;

  assign i_addr_ok = accept & (grant == OWN_I);
  assign d_addr_ok = accept & (grant == OWN_D);
  assign i_data_ok = ret & (head == OWN_I);
  assign d_data_ok = ret & (head == OWN_D);

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    unique case (lock_q)
      ARB_UNLOCKED: begin
        if (m_req && !m_addr_ok) begin
          lock_d       = ARB_LOCKED;
          lock_owner_d = grant;
        end
      end
      ARB_LOCKED: begin
        if (m_addr_ok) begin
          lock_d = ARB_UNLOCKED;
        end
      end
      default: lock_d = ARB_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q       <= ARB_UNLOCKED;
      lock_owner_q <= OWN_I;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end

endmodule

// File: tb/tb_sramlike_arbiter_2x1.sv
module tb_sramlike_arbiter_2x1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sramlike_arbiter_2x1 #(
    .MAX_OUTST (2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_req     (i_req),
    .i_wr      (i_wr),
    .i_size    (i_size),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_rdata   (i_rdata),
    .i_addr_ok (i_addr_ok),
    .i_data_ok (i_data_ok),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_addr_ok (d_addr_ok),
    .d_data_ok (d_data_ok),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_size    (m_size),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_addr_ok (m_addr_ok),
    .m_data_ok (m_data_ok)
  );

  // Inputs change 2 time units after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = '0; i_wdata = '0;
    d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = '0; d_wdata = '0;
    m_rdata = '0; m_addr_ok = 0; m_data_ok = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    clear_inputs();
    i_req = 1; d_req = 1; m_addr_ok = 1; m_data_ok = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      total++;
      if (m_req !== 1'b0) begin
        bad++; $display("FAIL reset_m_req got=%b want=0", m_req);
      end
      total++;
      if ({i_addr_ok, d_addr_ok} !== 2'b00) begin
        bad++; $display("FAIL reset_addr_ok got=%b%b want=00", i_addr_ok, d_addr_ok);
      end
      total++;
      if ({i_data_ok, d_data_ok} !== 2'b00) begin
        bad++; $display("FAIL reset_data_ok got=%b%b want=00", i_data_ok, d_data_ok);
      end
    end
    tick();
    resetn = 1;
    clear_inputs();
  endtask

  task automatic test_single_fetch();
    tick();
    i_req = 1; i_addr = 32'hBFC0_0000; m_addr_ok = 1;
    #1;
    total++;
    if (m_req !== 1'b1 || m_addr !== 32'hBFC0_0000) begin
      bad++; $display("FAIL fetch_cmd got req=%b addr=%h want req=1 addr=bfc00000", m_req, m_addr);
    end
    total++;
    if ({i_addr_ok, d_addr_ok} !== 2'b10) begin
      bad++; $display("FAIL fetch_addr_ok got=%b%b want=10", i_addr_ok, d_addr_ok);
    end
    tick();
    clear_inputs();
    tick();
    m_data_ok = 1; m_rdata = 32'h3C1D_0001;
    #1;
    total++;
    if ({i_data_ok, d_data_ok} !== 2'b10 || i_rdata !== 32'h3C1D_0001) begin
      bad++; $display("FAIL fetch_data got ok=%b%b rdata=%h want ok=10 rdata=3c1d0001",
                      i_data_ok, d_data_ok, i_rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_contention();
    tick();
    i_req = 1; i_addr = 32'hBFC0_0004;
    d_req = 1; d_addr = 32'h8000_1000; d_wr = 1; d_wdata = 32'h1234_5678;
    m_addr_ok = 1;
    #1;
    total++;
    if (m_addr !== 32'h8000_1000 || m_wr !== 1'b1 || m_wdata !== 32'h1234_5678) begin
      bad++; $display("FAIL cont_d_first got addr=%h wr=%b wdata=%h want 80001000/1/12345678",
                      m_addr, m_wr, m_wdata);
    end
    total++;
    if ({i_addr_ok, d_addr_ok} !== 2'b01) begin
      bad++; $display("FAIL cont_d_ok got=%b%b want=01", i_addr_ok, d_addr_ok);
    end
    tick();
    d_req = 0; d_wr = 0;
    #1;
    total++;
    if (m_addr !== 32'hBFC0_0004 || {i_addr_ok, d_addr_ok} !== 2'b10) begin
      bad++; $display("FAIL cont_i_next got addr=%h ok=%b%b want bfc00004 ok=10",
                      m_addr, i_addr_ok, d_addr_ok);
    end
    tick();
    clear_inputs();
    m_data_ok = 1; m_rdata = 32'hAAAA_0001;
    #1;
    total++;
    if ({i_data_ok, d_data_ok} !== 2'b01 || d_rdata !== 32'hAAAA_0001) begin
      bad++; $display("FAIL cont_ret_d got ok=%b%b rdata=%h want ok=01 rdata=aaaa0001",
                      i_data_ok, d_data_ok, d_rdata);
    end
    tick();
    m_data_ok = 1; m_rdata = 32'hBBBB_0002;
    #1;
    total++;
    if ({i_data_ok, d_data_ok} !== 2'b10) begin
      bad++; $display("FAIL cont_ret_i got=%b%b want=10", i_data_ok, d_data_ok);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_lock();
    tick();
    i_req = 1; i_addr = 32'hBFC0_0008;
    #1;
    total++;
    if (m_req !== 1'b1 || m_addr !== 32'hBFC0_0008 || i_addr_ok !== 1'b0) begin
      bad++; $display("FAIL lock_start got req=%b addr=%h iok=%b want 1/bfc00008/0",
                      m_req, m_addr, i_addr_ok);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      d_req = 1; d_addr = 32'h8000_2000;
      #1;
      total++;
      if (m_addr !== 32'hBFC0_0008 || d_addr_ok !== 1'b0) begin
        bad++; $display("FAIL lock_hold got addr=%h dok=%b want bfc00008/0", m_addr, d_addr_ok);
      end
    end
    tick();
    m_addr_ok = 1;
    #1;
    total++;
    if (m_addr !== 32'hBFC0_0008 || {i_addr_ok, d_addr_ok} !== 2'b10) begin
      bad++; $display("FAIL lock_release got addr=%h ok=%b%b want bfc00008 ok=10",
                      m_addr, i_addr_ok, d_addr_ok);
    end
    tick();
    i_req = 0;
    #1;
    total++;
    if (m_addr !== 32'h8000_2000 || {i_addr_ok, d_addr_ok} !== 2'b01) begin
      bad++; $display("FAIL lock_then_d got addr=%h ok=%b%b want 80002000 ok=01",
                      m_addr, i_addr_ok, d_addr_ok);
    end
    tick();
    clear_inputs();
    m_data_ok = 1;
    #1;
    total++;
    if ({i_data_ok, d_data_ok} !== 2'b10) begin
      bad++; $display("FAIL lock_ret_i got=%b%b want=10", i_data_ok, d_data_ok);
    end
    tick();
    m_data_ok = 1;
    #1;
    total++;
    if ({i_data_ok, d_data_ok} !== 2'b01) begin
      bad++; $display("FAIL lock_ret_d got=%b%b want=01", i_data_ok, d_data_ok);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_full();
    tick();
    d_req = 1; d_addr = 32'h8000_3000; m_addr_ok = 1;
    #1;
    total++;
    if (d_addr_ok !== 1'b1) begin
      bad++; $display("FAIL full_acc1 got=%b want=1", d_addr_ok);
    end
    tick();
    d_addr = 32'h8000_3004;
    #1;
    total++;
    if (d_addr_ok !== 1'b1) begin
      bad++; $display("FAIL full_acc2 got=%b want=1", d_addr_ok);
    end
    tick();
    d_addr = 32'h8000_3008;
    #1;
    total++;
    if (m_req !== 1'b0 || d_addr_ok !== 1'b0) begin
      bad++; $display("FAIL full_block got req=%b dok=%b want 0/0", m_req, d_addr_ok);
    end
    // Return while full: no same-cycle credit.
    tick();
    m_data_ok = 1;
    #1;
    total++;
    if (m_req !== 1'b0 || d_data_ok !== 1'b1) begin
      bad++; $display("FAIL full_ret got req=%b dok=%b want 0/1", m_req, d_data_ok);
    end
    tick();
    m_data_ok = 0;
    #1;
    total++;
    if (m_req !== 1'b1 || d_addr_ok !== 1'b1) begin
      bad++; $display("FAIL full_reopen got req=%b aok=%b want 1/1", m_req, d_addr_ok);
    end
    tick();
    d_addr = 32'h8000_300C; m_data_ok = 1;
    #1;
    total++;
    if (m_req !== 1'b0 || d_data_ok !== 1'b1) begin
      bad++; $display("FAIL full_again got req=%b dok=%b want 0/1", m_req, d_data_ok);
    end
    // One outstanding: accept and return together, count stays at one.
    tick();
    m_data_ok = 1;
    #1;
    total++;
    if ({d_addr_ok, d_data_ok} !== 2'b11) begin
      bad++; $display("FAIL full_push_pop got aok=%b dok=%b want 1/1", d_addr_ok, d_data_ok);
    end
    tick();
    d_req = 0; m_data_ok = 1;
    #1;
    total++;
    if (d_data_ok !== 1'b1) begin
      bad++; $display("FAIL full_last_ret got=%b want=1", d_data_ok);
    end
    tick();
    m_data_ok = 1;
    #1;
    total++;
    if ({i_data_ok, d_data_ok} !== 2'b00) begin
      bad++; $display("FAIL spurious_ret got=%b%b want=00", i_data_ok, d_data_ok);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    tick();
    i_req = 1; i_addr = 32'hBFC0_0100; m_addr_ok = 1;
    tick();
    i_addr = 32'hBFC0_0104;
    #1;
    total++;
    if (i_addr_ok !== 1'b1) begin
      bad++; $display("FAIL mid_acc2 got=%b want=1", i_addr_ok);
    end
    tick();
    clear_inputs();
    resetn = 0; m_data_ok = 1;
    #1;
    total++;
    if (i_data_ok !== 1'b0) begin
      bad++; $display("FAIL mid_in_reset got=%b want=0", i_data_ok);
    end
    tick();
    resetn = 1; m_data_ok = 1;
    #1;
    total++;
    if ({i_data_ok, d_data_ok} !== 2'b00) begin
      bad++; $display("FAIL mid_after_reset got=%b%b want=00", i_data_ok, d_data_ok);
    end
    tick();
    m_data_ok = 0; i_req = 1; i_addr = 32'hBFC0_0200; m_addr_ok = 1;
    #1;
    total++;
    if (m_req !== 1'b1 || i_addr_ok !== 1'b1) begin
      bad++; $display("FAIL mid_reopen got req=%b iok=%b want 1/1", m_req, i_addr_ok);
    end
    tick();
    clear_inputs();
    m_data_ok = 1; m_rdata = 32'h0000_00C3;
    #1;
    total++;
    if (i_data_ok !== 1'b1 || i_rdata !== 32'h0000_00C3) begin
      bad++; $display("FAIL mid_ret got ok=%b rdata=%h want 1/000000c3", i_data_ok, i_rdata);
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_lock();
    test_full();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
